// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared segment constants and types for the seven-segment scanner
package seg_scan_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] DIG_OFF   = 8'hFF;

    // Active-high {g,f,e,d,c,b,a} patterns for 0-9 and A,b,C,d,E,F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex nibble to seven-segment pattern decode
module hex7seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment scanner with frame-aligned data commit (option: LEAD_ZERO_BLANK_EN)
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] dataIn,
    input  logic [7:0]  dotIn,
    output logic        pending,
    output logic        frameDone,
    output logic [7:0]  segOut,
    output logic [7:0]  digOut
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    digit_idx_t    idx;
    logic [39:0]   shadow;
    logic [39:0]   pendReg;
    logic [7:0]    dot;
    logic [3:0]    nibble;
    logic [6:0]    hexSeg;
    logic          tick;
    logic          boundary;
    logic          blank;
    logic          show;

    assign dot      = shadow[39:32];
    assign tick     = div == DW'(CLK_DIV - 1);
    assign boundary = tick && idx == 3'd7;
    assign blank    = div < DW'(BLANK_CYC);
    assign nibble   = shadow[{idx, 2'b00} +: 4];

    hex7seg_decode u_decode (
        .nibble(nibble),
        .seg   (hexSeg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    digit_idx_t hiIdx;

    // Highest digit holding a nonzero nibble; digit 0 when the whole word is zero
    always_comb begin
        hiIdx = '0;
        for (int k = 1; k < 8; k++)
            if (shadow[4*k +: 4] != 4'h0) hiIdx = digit_idx_t'(k);
    end

    assign show = idx == 3'd0 || idx <= hiIdx || dot[idx];
`else
    assign show = 1'b1;
`endif

    // Slot prescaler and digit index; the index advances once per slot
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) idx <= idx + 1'b1;
        end
    end

    // Capture loads into pendReg and commit to shadow only at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pendReg   <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= boundary;
            if (load) pendReg <= {dotIn, dataIn};
            if (boundary && load) begin
                shadow  <= {dotIn, dataIn};
                pending <= 1'b0;
            end else if (boundary && pending) begin
                shadow  <= pendReg;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered digit/segment drive, dark during the anti-ghosting window
    always_ff @(posedge clk) begin
        if (rst) begin
            digOut <= DIG_OFF;
            segOut <= SEG_BLANK;
        end else begin
            digOut <= (blank || !show) ? DIG_OFF : ~(8'b1 << idx);
            segOut <= (blank || !show) ? SEG_BLANK : {dot[idx], hexSeg};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int CD = 4;
    localparam int BL = 1;
    localparam int FR = 8 * CD;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] dataIn = '0;
    logic [7:0]  dotIn = '0;
    logic        pending;
    logic        frameDone;
    logic [7:0]  segOut;
    logic [7:0]  digOut;

    seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BL)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dataIn   (dataIn),
        .dotIn    (dotIn),
        .pending  (pending),
        .frameDone(frameDone),
        .segOut   (segOut),
        .digOut   (digOut)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          mCyc;
    logic [39:0] mShadow;
    logic [39:0] mPendVal;
    logic        mPend;
    logic [7:0]  eDig;
    logic [7:0]  eSeg;
    logic        ePend;
    logic        eFrame;
    logic [7:0]  capSeg [8];
    logic [7:0]  capSeen;

    // What the display should show for cycle c of the scan with the given committed word
    function automatic logic [15:0] disp(int c, logic [39:0] sh);
        int d = c % CD;
        int i = (c / CD) % 8;
        bit showIt = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
        int hi = 0;
        for (int k = 0; k < 8; k++) if (sh[4*k +: 4] != 4'h0) hi = k;
        showIt = (i == 0) || (i <= hi) || sh[32+i];
`endif
        if (d < BL || !showIt) return {8'hFF, 8'h00};
        return {~(8'd1 << i), sh[32+i], HEX[sh[4*i +: 4]]};
    endfunction

    // Advance one clock, update the reference model, then record which digit lit
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            mCyc = 0; mShadow = '0; mPend = 1'b0; mPendVal = '0;
            eDig = 8'hFF; eSeg = 8'h00; eFrame = 1'b0;
        end else begin
            {eDig, eSeg} = disp(mCyc, mShadow);
            eFrame = (mCyc % FR) == FR - 1;
            if (eFrame && load) begin
                mShadow = {dotIn, dataIn}; mPend = 1'b0;
            end else if (eFrame && mPend) begin
                mShadow = mPendVal; mPend = 1'b0;
            end else if (load) begin
                mPendVal = {dotIn, dataIn}; mPend = 1'b1;
            end
            mCyc++;
        end
        ePend = mPend;
        #1;
        for (int k = 0; k < 8; k++)
            if (digOut === ~(8'd1 << k)) begin capSeg[k] = segOut; capSeen[k] = 1'b1; end
    endtask

    task automatic test_reset();
        bit found = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            cycle();
            if ({digOut, segOut, pending} !== {8'hFF, 8'h00, 1'b0}) begin
                bad++; $display("FAIL reset got dig=%h seg=%h pend=%b want dig=ff seg=00 pend=0", digOut, segOut, pending);
            end
            total++;
        end
        rst = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL reset_run cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
            found = digOut !== 8'hFF;
        end
        if (!found || digOut !== 8'hFE || segOut !== 8'h3F) begin
            bad++; $display("FAIL first_lit got dig=%h seg=%h want dig=fe seg=3f", digOut, segOut);
        end
        total++;
    endtask

    task automatic test_load_basic();
        bit found = 1'b0;
        int fd = 0;
        load = 1'b1; dataIn = 32'h76543210; dotIn = 8'h01;
        cycle();
        load = 1'b0;
        if (pending !== 1'b1) begin bad++; $display("FAIL load_pending got %b want 1", pending); end
        total++;
        for (int n = 0; n < FR + 2 && !found; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL load_wait cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
            found = frameDone === 1'b1;
        end
        if (!found || pending !== 1'b0) begin bad++; $display("FAIL load_commit got fd=%b pend=%b want fd=1 pend=0", found, pending); end
        total++;
        capSeen = '0;
        for (int n = 0; n < FR; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL load_frame cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
            fd += int'(frameDone);
        end
        if (capSeg[0] !== 8'hBF || capSeg[7] !== 8'h07 || capSeen !== 8'hFF) begin
            bad++; $display("FAIL load_digits got d0=%h d7=%h seen=%h want bf 07 ff", capSeg[0], capSeg[7], capSeen);
        end
        total++;
        if (fd != 1 || frameDone !== 1'b1) begin bad++; $display("FAIL frame_period got pulses=%0d last=%b want 1 1", fd, frameDone); end
        total++;
    endtask

    task automatic test_mid_frame();
        bit found = 1'b0;
        repeat (12) cycle();
        load = 1'b1; dataIn = 32'hFEDCBA98; dotIn = 8'h00;
        cycle();
        load = 1'b0;
        capSeen = '0;
        for (int n = 0; n < FR + 2 && !found; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL mid_old cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
            found = frameDone === 1'b1;
        end
        if (!found || capSeg[5] !== 8'h6D || capSeg[7] !== 8'h07) begin
            bad++; $display("FAIL mid_keeps_old got d5=%h d7=%h want 6d 07", capSeg[5], capSeg[7]);
        end
        total++;
        capSeen = '0;
        for (int n = 0; n < FR; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL mid_new cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
        end
        for (int k = 0; k < 8; k++) begin
            if (capSeg[k] !== {1'b0, HEX[8+k]} || capSeen[k] !== 1'b1) begin
                bad++; $display("FAIL mid_digit%0d got %h want %h", k, capSeg[k], {1'b0, HEX[8+k]});
            end
            total++;
        end
    endtask

    task automatic test_boundary_load();
        bit found = 1'b0;
        for (int n = 0; n < FR + 2 && !found; n++) begin
            found = (mCyc % FR) == FR - 1;
            if (!found) cycle();
        end
        load = 1'b1; dataIn = 32'h13579BDF; dotIn = 8'h80;
        cycle();
        load = 1'b0;
        if (!found || pending !== 1'b0 || frameDone !== 1'b1) begin
            bad++; $display("FAIL boundary_load got pend=%b fd=%b want pend=0 fd=1", pending, frameDone);
        end
        total++;
        capSeen = '0;
        for (int n = 0; n < FR; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL boundary_frame cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
        end
        if (capSeg[0] !== 8'h71 || capSeg[7] !== 8'h86) begin
            bad++; $display("FAIL boundary_digits got d0=%h d7=%h want 71 86", capSeg[0], capSeg[7]);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int n = 0; n < FR + 2 && !found; n++) begin
            found = (mCyc % FR) == 5 * CD + 1;
            if (!found) cycle();
        end
        load = 1'b1; dataIn = 32'h11111111; dotIn = 8'hFF;
        cycle();
        load = 1'b0;
        if (!found || pending !== 1'b1) begin bad++; $display("FAIL rstmid_pending got %b want 1", pending); end
        total++;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        if ({digOut, segOut, pending, frameDone} !== {8'hFF, 8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rstmid got dig=%h seg=%h pend=%b fd=%b want ff 00 0 0", digOut, segOut, pending, frameDone);
        end
        total++;
        capSeen = '0;
        for (int n = 0; n < FR; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL rstmid_run cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
        end
`ifdef LEAD_ZERO_BLANK_EN
        if (capSeg[0] !== 8'h3F || capSeen !== 8'h01) begin
            bad++; $display("FAIL rstmid_shadow got d0=%h seen=%h want 3f 01", capSeg[0], capSeen);
        end
`else
        if (capSeg[0] !== 8'h3F || capSeg[5] !== 8'h3F) begin
            bad++; $display("FAIL rstmid_shadow got d0=%h d5=%h want 3f 3f", capSeg[0], capSeg[5]);
        end
`endif
        total++;
    endtask

    task automatic test_lead_zero();
        bit found = 1'b0;
        load = 1'b1; dataIn = 32'h00000120; dotIn = 8'h00;
        cycle();
        load = 1'b0;
        for (int n = 0; n < FR + 2 && !found; n++) begin
            cycle();
            found = frameDone === 1'b1;
        end
        capSeen = '0;
        for (int n = 0; n < FR; n++) begin
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL lz_run cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
        end
        if (!found || capSeg[0] !== 8'h3F || capSeg[1] !== 8'h5B || capSeg[2] !== 8'h06) begin
            bad++; $display("FAIL lz_low got d0=%h d1=%h d2=%h want 3f 5b 06", capSeg[0], capSeg[1], capSeg[2]);
        end
        total++;
`ifdef LEAD_ZERO_BLANK_EN
        if (capSeen[7:3] !== 5'b0) begin bad++; $display("FAIL lz_high got seen=%b want 00000", capSeen[7:3]); end
        total++;
`else
        for (int k = 3; k < 8; k++) begin
            if (capSeg[k] !== 8'h3F) begin bad++; $display("FAIL lz_digit%0d got %h want 3f", k, capSeg[k]); end
            total++;
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            load = $urandom_range(0, 7) == 0;
            dataIn = $urandom & $urandom;
            dotIn = 8'($urandom & $urandom & $urandom);
            rst = $urandom_range(0, 199) == 0;
            cycle();
            if ({digOut, segOut, pending, frameDone} !== {eDig, eSeg, ePend, eFrame}) begin
                bad++; $display("FAIL random cyc=%0d got %h %h %b %b want %h %h %b %b", mCyc, digOut, segOut, pending, frameDone, eDig, eSeg, ePend, eFrame);
            end
            total++;
        end
        load = 1'b0; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_mid_frame();
        test_boundary_load();
        test_reset_mid();
        test_lead_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
